mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 bit multiplexer between eight requesters. It drives the mux select and a one-hot grant vector. Each grant is held until the owner drops its request or a programmable hold limit expires, then ownership rotates. It sits directly in front of the 8-input select mux and is the only source of that mux's `sel`.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one requester may own the mux. Legal range is 1..15.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req` input, 8 bits: request vector; `req[i]` is requester i asking for the mux.
- `sel` output, 3 bits: select code for the 8:1 mux; equals the index of the current owner.
- `gnt` output, 8 bits: one-hot grant; `gnt[i]`=1 means requester i owns the mux.
- `busy` output, 1 bit: 1 while any grant is active.

## Operation
- The state machine has two states, IDLE and GRANT. Internal registers are `ptr` (3 bits, rotation start index) and `cnt` (4 bits, hold counter).
- **Arbitration function.** Search `req` starting at index `ptr`, then `ptr+1`, continuing modulo 8. The first set bit wins.
- **IDLE:**
  - Outputs are `gnt`=0 and `busy`=0. `sel` holds its last value.
  - If `req`≠0 at an edge: state becomes GRANT, the winner is registered into `sel`/`gnt`, and `cnt`=0.
- **GRANT:** release is decided at each edge, using the `req` sampled at that edge.
  - Release condition: `req[sel]`==0 OR `cnt`==`HOLD_MAX`-1.
  - No release: `cnt`<=`cnt`+1, and `sel`/`gnt` are unchanged.
  - Release: `ptr`<=`sel`+1 (mod 8, so 7 wraps to 0), and a new search runs from `sel`+1.
    - If any `req` bit is set, the winner is granted at the same edge with `cnt`=0 and no idle bubble.
    - If none is set, the state goes to IDLE.
  - On hold expiry with the current owner still requesting, the owner is searched last. It is re-granted only if it is the sole requester.
- **Invariants:**
  - `gnt` is zero or one-hot.
  - `gnt`=1<<`sel` whenever `busy`=1.
  - `busy`=|`gnt`.
- **Width rules.** `cnt` is never compared beyond `HOLD_MAX`-1, so no overflow is possible. The `sel`+1 increment is 3-bit wrap-around.
- **Reset:**
  - On `rst` asserted, the state goes to IDLE with `gnt`=0, `sel`=0, `busy`=0, `ptr`=0, `cnt`=0.
  - These values take effect immediately, even mid-grant, without waiting for a clock edge.
  - After reset deasserts, the first arbitration starts at index 0.

## Timing
- Request to grant latency is 1 cycle from IDLE: `req` is sampled at edge N and `gnt` is valid after edge N.
- Handover is 0 bubble cycles. The old `gnt` falls and the new `gnt` rises at the same edge.
- Drop to release latency is 1 edge. Owner's `req` low at edge N means `gnt` is deasserted after edge N; the owner holds the mux through cycle N.
- Maximum tenure is exactly `HOLD_MAX` cycles.
- Worst-case wait for a continuously requesting input is 7×`HOLD_MAX` cycles.
- All outputs are registered, with no combinational path from `req` to the outputs.
- `req` changes between edges have no effect.

## Test plan
- **Reset:** assert `rst` mid-simulation while `gnt`=8'h10. Required: `gnt`=8'h00, `sel`=0, `busy`=0 before the next edge. After release with `req`=8'hFF, first grant is `gnt`=8'h01.
- **Sole requester, `HOLD_MAX`=4:** hold `req`=8'h20 for 10 cycles. Required: `gnt`=8'h20 and `sel`=5 from cycle 1 continuously through expiry re-grants, with `busy` never dropping. After `req` drops, `gnt`=0 one edge later.
- **Full contention:** `req`=8'hFF steady, `HOLD_MAX`=4. Required: `sel` sequence 0,1,2,…,7,0, each value held exactly 4 cycles. `gnt` stays one-hot every cycle.
- **Early release:** `req[2]` asserted for 2 granted cycles while `req[6]` is pending. Required: `gnt`=8'h04 for 2 cycles, then 8'h40 on the very next cycle, with no zero cycle between.
- **Wrap and fairness:** `req`=8'h81 with current owner 7. Required: on expiry the next grant is 0, not 7. After owner 0 expires, the next grant is 7.
- **`HOLD_MAX`=1:** `req`=8'h0A. Required: grants alternate 1,3,1,3 every cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that owns the select of an 8:1 bit mux.
// A grant is held until the owner drops its request or HOLD_MAX cycles pass,
// then ownership rotates, starting the search just after the released owner.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   req  - [7:0] request vector, req[i] = requester i wants the mux
//   sel  - [2:0] mux select, index of the current owner (held while idle)
//   gnt  - [7:0] one-hot grant, zero when idle
//   busy - 1 while a grant is active
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_sel;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_busy;

  logic [SEL_W-1:0]   w_start;
  logic               w_release;
  logic               w_found;
  logic [SEL_W-1:0]   w_win;

  // First set bit of req_v scanning start, start+1, ... modulo 8.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [SEL_W:0] f_search(input logic [N_REQ-1:0] req_v,
                                               input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req_v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // From IDLE search from the rotation pointer; on release search from the
  // slot after the owner, which leaves the owner itself as the last candidate.
  always_comb begin
    w_start   = (r_state == ST_IDLE) ? r_ptr : r_sel + SEL_W'(1);
    w_release = !req[r_sel] || (r_cnt == CNT_W'(HOLD_MAX - 1));
    {w_found, w_win} = f_search(req, w_start);
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_sel   <= w_win;
            r_gnt   <= N_REQ'(1) << w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (!w_release) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_ptr <= r_sel + SEL_W'(1);
            r_cnt <= '0;
            if (w_found) begin
              r_sel <= w_win;
              r_gnt <= N_REQ'(1) << w_win;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with HOLD_MAX=4 and one
// with HOLD_MAX=1 share clock, reset and request inputs.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [2:0] sel4, sel1;
  logic [7:0] gnt4, gnt1;
  logic       busy4, busy1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .sel(sel4), .gnt(gnt4), .busy(busy4)
  );

  mux_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .sel(sel1), .gnt(gnt1), .busy(busy1)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-style reset pulse leaving both DUTs idle with ptr=0.
  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'h00;
    #1;
    n_total++;
    if (gnt4 !== 8'h00 || sel4 !== 3'd0 || busy4 !== 1'b0)
      $display("FAIL reset_initial gnt=%h sel=%0d busy=%b want 00/0/0", gnt4, sel4, busy4);
    else n_pass++;
    step();
    rst = 1'b0;
    req = 8'h10;
    step();
    n_total++;
    if (gnt4 !== 8'h10 || sel4 !== 3'd4 || busy4 !== 1'b1)
      $display("FAIL reset_pregrant gnt=%h sel=%0d busy=%b want 10/4/1", gnt4, sel4, busy4);
    else n_pass++;
    // Assert reset mid-cycle; outputs must clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (gnt4 !== 8'h00 || sel4 !== 3'd0 || busy4 !== 1'b0)
      $display("FAIL reset_async gnt=%h sel=%0d busy=%b want 00/0/0", gnt4, sel4, busy4);
    else n_pass++;
    req = 8'hFF;
    #1;
    rst = 1'b0;
    step();
    n_total++;
    if (gnt4 !== 8'h01 || sel4 !== 3'd0 || busy4 !== 1'b1)
      $display("FAIL reset_first_grant gnt=%h sel=%0d busy=%b want 01/0/1", gnt4, sel4, busy4);
    else n_pass++;
  endtask

  // A request pulse entirely between edges must not be seen.
  task automatic test_glitch();
    do_reset();
    #2;
    req = 8'hFF;
    #3;
    req = 8'h00;
    step();
    n_total++;
    if (gnt4 !== 8'h00 || busy4 !== 1'b0)
      $display("FAIL glitch gnt=%h busy=%b want 00/0", gnt4, busy4);
    else n_pass++;
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 8'h20;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_total++;
      if (gnt4 !== 8'h20 || sel4 !== 3'd5 || busy4 !== 1'b1)
        $display("FAIL sole_hold c=%0d gnt=%h sel=%0d busy=%b want 20/5/1", c, gnt4, sel4, busy4);
      else n_pass++;
    end
    req = 8'h00;
    step();
    n_total++;
    if (gnt4 !== 8'h00 || busy4 !== 1'b0 || sel4 !== 3'd5)
      $display("FAIL sole_drop gnt=%h busy=%b sel=%0d want 00/0/5", gnt4, busy4, sel4);
    else n_pass++;
  endtask

  task automatic test_full_contention();
    logic [2:0] exp_sel;
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      step();
      exp_sel = 3'((c / 4) % 8);
      exp_gnt = 8'h01 << exp_sel;
      n_total++;
      if (sel4 !== exp_sel || gnt4 !== exp_gnt || busy4 !== 1'b1)
        $display("FAIL contention c=%0d sel=%0d gnt=%h busy=%b want %0d/%h/1",
                 c, sel4, gnt4, busy4, exp_sel, exp_gnt);
      else n_pass++;
    end
  endtask

  task automatic test_early_release();
    logic [7:0] exp_g [4];
    logic [7:0] req_v [4];
    exp_g = '{8'h04, 8'h04, 8'h40, 8'h00};
    req_v = '{8'h44, 8'h44, 8'h40, 8'h00};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req = req_v[c];
      step();
      n_total++;
      if (gnt4 !== exp_g[c])
        $display("FAIL early_release c=%0d gnt=%h want %h", c, gnt4, exp_g[c]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_fairness();
    logic [7:0] exp_g [8];
    exp_g = '{8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80};
    do_reset();
    req = 8'h80;
    step();
    n_total++;
    if (gnt4 !== 8'h80 || sel4 !== 3'd7)
      $display("FAIL wrap_owner7 gnt=%h sel=%0d want 80/7", gnt4, sel4);
    else n_pass++;
    req = 8'h81;
    for (int c = 0; c < 8; c++) begin
      step();
      n_total++;
      if (gnt4 !== exp_g[c])
        $display("FAIL wrap c=%0d gnt=%h want %h", c, gnt4, exp_g[c]);
      else n_pass++;
    end
  endtask

  task automatic test_hold_one();
    logic [2:0] exp_sel;
    do_reset();
    req = 8'h0A;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_sel = (c % 2 == 0) ? 3'd1 : 3'd3;
      n_total++;
      if (sel1 !== exp_sel || gnt1 !== (8'h01 << exp_sel) || busy1 !== 1'b1)
        $display("FAIL hold_one c=%0d sel=%0d gnt=%h busy=%b want sel %0d",
                 c, sel1, gnt1, busy1, exp_sel);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_sole_requester();
    test_full_contention();
    test_early_release();
    test_wrap_fairness();
    test_hold_one();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
